// File: rtl/alu_flag_stage.sv
// alu_flag_stage: valid/ready sequencer and flag/accumulator register around the combinational ALU.
// Define ALU_FLAG_STAGE_STICKY_V_EN to make the v flag sticky until flag_clr or rst.
module alu_flag_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_opcode,
  input  logic             in_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_n,
  input  logic             alu_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [WIDTH-1:0] acc,
  input  logic             flag_clr
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic [3:0]       flags_q, flags_d;
  logic             accept, v_cap;
  assign in_ready = !rst && (state_q == IDLE || (state_q == DONE && out_ready));
  assign accept   = in_valid && in_ready;
`ifdef ALU_FLAG_STAGE_STICKY_V_EN
  // flag_clr during capture restarts v from the new ALU value
  assign v_cap = flag_clr ? alu_v : (flags_q[0] | alu_v);
`else
  assign v_cap = alu_v;
`endif
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    if (accept) begin
      a_d     = in_use_acc ? acc_q : in_a;
      b_d     = in_b;
      op_d    = in_opcode;
      state_d = EXEC;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
    if (state_q == EXEC) begin
      res_d   = alu_result;
      acc_d   = alu_result;
      flags_d = {alu_z, alu_c, alu_n, v_cap};
      state_d = DONE;
    end else if (flag_clr) begin
      flags_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign out_valid  = state_q == DONE;
  assign out_result = res_q;
  assign out_flags  = flags_q;
  assign acc        = acc_q;
endmodule

// File: tb/tb_alu_flag_stage.sv
// tb_alu_flag_stage: randomized and directed checks of alu_flag_stage against a behavioural model.
module tb_alu_flag_stage;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, in_use_acc, out_valid, out_ready, flag_clr;
  logic [7:0] in_a, in_b, alu_a, alu_b, alu_result, out_result, acc;
  logic [2:0] in_opcode, alu_op;
  logic       alu_z, alu_c, alu_n, alu_v;
  logic [3:0] out_flags;
  int         checks = 0, failures = 0;
  logic [7:0] m_acc, exp_a, exp_b;
  logic [2:0] exp_op;
  logic [3:0] m_flags;

  always #5 clk = ~clk;

  alu_flag_stage #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode), .in_use_acc(in_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_z(alu_z), .alu_c(alu_c), .alu_n(alu_n), .alu_v(alu_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .acc(acc), .flag_clr(flag_clr)
  );

  // Behavioural ALU: returns {z,c,n,v,result}
  function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    s = 9'd0;
    r = 8'd0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin r = a - b; c = a < b; v = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = {a[6:0], 1'b0}; c = a[7]; end
      3'd6: begin r = {1'b0, a[7:1]}; c = a[0]; end
      default: r = 8'd0;
    endcase
    return {r == 8'd0, c, r[7], v, r};
  endfunction

  always_comb {alu_z, alu_c, alu_n, alu_v, alu_result} = alu_f(alu_a, alu_b, alu_op);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_capture(input logic clr);
    logic [11:0] f;
    f = alu_f(exp_a, exp_b, exp_op);
    m_acc = f[7:0];
`ifdef ALU_FLAG_STAGE_STICKY_V_EN
    m_flags = {f[11:9], clr ? f[8] : (m_flags[0] | f[8])};
`else
    m_flags = f[11:8];
`endif
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic ua);
    in_a = a; in_b = b; in_opcode = op; in_use_acc = ua; in_valid = 1'b1;
    exp_a = ua ? m_acc : a; exp_b = b; exp_op = op;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
    step();
    rst = 1'b0;
    m_acc = 8'd0; m_flags = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; flag_clr = 1'b0;
    in_a = 8'h11; in_b = 8'h22; in_opcode = 3'd0; in_use_acc = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    end
    rst = 1'b0; in_valid = 1'b0;
    m_acc = 8'd0; m_flags = 4'd0;
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", out_result); end
    checks++; if (out_flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", out_flags); end
    checks++; if (acc !== 8'h00) begin failures++; $display("FAIL reset_acc got=%h exp=00", acc); end
    checks++; if ({alu_a, alu_b, alu_op} !== 19'd0) begin failures++; $display("FAIL reset_alu_in got=%h/%h/%b exp=0", alu_a, alu_b, alu_op); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_release_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_add_overflow();
    issue(8'h7F, 8'h01, 3'd0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_exec_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL add_exec_ready got=%b exp=0", in_ready); end
    checks++; if ({alu_a, alu_b, alu_op} !== {8'h7F, 8'h01, 3'd0}) begin failures++; $display("FAIL add_alu_in got=%h/%h/%b exp=7f/01/000", alu_a, alu_b, alu_op); end
    step(); model_capture(1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    checks++; if (out_result !== 8'h80) begin failures++; $display("FAIL add_result got=%h exp=80", out_result); end
    checks++; if (out_flags !== 4'b0011) begin failures++; $display("FAIL add_flags got=%b exp=0011", out_flags); end
    checks++; if (acc !== 8'h80) begin failures++; $display("FAIL add_acc got=%h exp=80", acc); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_drop_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_sub_accumulate();
    do_reset();
    issue(8'h05, 8'h07, 3'd1, 1'b0);
    step(); model_capture(1'b0);
    checks++; if (out_result !== 8'hFE) begin failures++; $display("FAIL sub_result got=%h exp=fe", out_result); end
    checks++; if (out_flags !== 4'b0110) begin failures++; $display("FAIL sub_flags got=%b exp=0110", out_flags); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    issue(8'hAA, 8'h0F, 3'd2, 1'b1);
    checks++; if (alu_a !== 8'hFE) begin failures++; $display("FAIL acc_operand got=%h exp=fe", alu_a); end
    step(); model_capture(1'b0);
    checks++; if (out_result !== 8'h0E) begin failures++; $display("FAIL and_acc_result got=%h exp=0e", out_result); end
    checks++; if (out_flags !== 4'b0000) begin failures++; $display("FAIL and_acc_flags got=%b exp=0000", out_flags); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] r;
    logic [3:0] f;
    issue(8'h33, 8'h44, 3'd3, 1'b0);
    step(); model_capture(1'b0);
    r = m_acc; f = m_flags;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if ({out_valid, out_result, out_flags, in_ready} !== {1'b1, r, f, 1'b0}) begin
        failures++; $display("FAIL hold_%0d got=%b/%h/%b/%b exp=1/%h/%b/0", i, out_valid, out_result, out_flags, in_ready, r, f);
      end
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    issue(8'h00, 8'h0F, 3'd4, 1'b1);
    out_ready = 1'b0;
    checks++; if ({out_valid, alu_a} !== {1'b0, r}) begin failures++; $display("FAIL b2b_exec got=%b/%h exp=0/%h", out_valid, alu_a, r); end
    step(); model_capture(1'b0);
    checks++; if ({out_valid, out_result, acc} !== {1'b1, m_acc, m_acc}) begin failures++; $display("FAIL b2b_result got=%b/%h/%h exp=1/%h", out_valid, out_result, acc, m_acc); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_sticky_v();
    do_reset();
    issue(8'h7F, 8'h01, 3'd0, 1'b0); step(); model_capture(1'b0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    issue(8'hFF, 8'h00, 3'd2, 1'b0); step(); model_capture(1'b0);
`ifdef ALU_FLAG_STAGE_STICKY_V_EN
    checks++; if (out_flags !== 4'b1001) begin failures++; $display("FAIL sticky_flags got=%b exp=1001", out_flags); end
`else
    checks++; if (out_flags !== 4'b1000) begin failures++; $display("FAIL sticky_flags got=%b exp=1000", out_flags); end
`endif
    flag_clr = 1'b1; step(); flag_clr = 1'b0; m_flags = 4'd0;
    checks++; if ({out_flags, out_result, acc, out_valid} !== {4'b0000, 8'h00, 8'h00, 1'b1}) begin
      failures++; $display("FAIL clr_done got=%b/%h/%h/%b exp=0000/00/00/1", out_flags, out_result, acc, out_valid);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    issue(8'h7F, 8'h01, 3'd0, 1'b0); step(); model_capture(1'b0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    issue(8'h01, 8'h01, 3'd0, 1'b0);
    flag_clr = 1'b1; step(); flag_clr = 1'b0; model_capture(1'b1);
    checks++; if (out_flags !== 4'b0000) begin failures++; $display("FAIL clr_exec got=%b exp=0000", out_flags); end
    checks++; if (out_result !== 8'h02) begin failures++; $display("FAIL clr_exec_result got=%h exp=02", out_result); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    issue(8'h12, 8'h34, 3'd0, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    m_acc = 8'd0; m_flags = 4'd0;
    checks++; if ({out_valid, acc, out_flags} !== {1'b0, 8'h00, 4'b0000}) begin
      failures++; $display("FAIL mid_reset got=%b/%h/%b exp=0/00/0000", out_valid, acc, out_flags);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_no_result_%0d got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_random();
    logic b2b;
    b2b = 1'b0;
    for (int n = 0; n < 40; n++) begin
      out_ready = b2b; #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rnd_ready_%0d got=%b exp=1", n, in_ready); end
      issue(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom));
      out_ready = 1'b0;
      checks++; if ({out_valid, alu_a, alu_b, alu_op} !== {1'b0, exp_a, exp_b, exp_op}) begin
        failures++; $display("FAIL rnd_issue_%0d got=%b/%h/%h/%b exp=0/%h/%h/%b", n, out_valid, alu_a, alu_b, alu_op, exp_a, exp_b, exp_op);
      end
      step(); model_capture(1'b0);
      for (int h = 0; h <= int'($urandom_range(0, 2)); h++) begin
        checks++; if ({out_valid, out_result, out_flags, acc} !== {1'b1, m_acc, m_flags, m_acc}) begin
          failures++; $display("FAIL rnd_result_%0d got=%b/%h/%b/%h exp=1/%h/%b/%h", n, out_valid, out_result, out_flags, acc, m_acc, m_flags, m_acc);
        end
        if (h > 0) step();
      end
      b2b = 1'($urandom);
      if (!b2b) begin
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rnd_drop_%0d got=%b exp=0", n, out_valid); end
      end
    end
    if (b2b) begin
      out_ready = 1'b1; step(); out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_accumulate();
    test_back_to_back();
    test_sticky_v();
    test_reset_mid_exec();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
